// File: rtl/mem_bus_master_if.sv
// Bundle of user command, completion and arbiter-side signals for mem_bus_master.
// The master modport is the block's view; the slave modport is the user/arbiter side.
interface mem_bus_master_if;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned LEN_W  = 4;

   // user command channel
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [DATA_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic [LEN_W-1:0]  req_len;

   // completion channel
   logic [DATA_W-1:0] rdata;
   logic              rdata_valid;
   logic              done;
   logic              err;

   // arbiter channel
   logic              mem_en;
   logic              mem_burst_en;
   logic [DATA_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_di;
   logic              mem_we;
   logic              do_ack;
   logic [DATA_W-1:0] mem_do;

   modport master (
      input  req_valid, req_we, req_addr, req_wdata, req_len, do_ack, mem_do,
      output req_ready, rdata, rdata_valid, done, err,
             mem_en, mem_burst_en, mem_addr, mem_di, mem_we
   );

   modport slave (
      output req_valid, req_we, req_addr, req_wdata, req_len, do_ack, mem_do,
      input  req_ready, rdata, rdata_valid, done, err,
             mem_en, mem_burst_en, mem_addr, mem_di, mem_we
   );
endinterface

// File: rtl/mem_bus_master.sv
// Single-command memory bus master: one write beat or a read burst of up to MAX_LEN beats,
// with a per-beat acknowledge timeout. All outputs are registered.
module mem_bus_master #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned MAX_LEN = 16
) (
   input logic              clk,
   input logic              reset,
   mem_bus_master_if.master bus
);
   localparam int unsigned DATA_W = 32;
   localparam int unsigned LEN_W  = 4;
   localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [LEN_W-1:0] LEN_MAX = (MAX_LEN >= 16) ? LEN_W'(15) : LEN_W'(MAX_LEN - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, REQ, BURST, DONE} state_t;

   state_t state, state_d;

   logic              ready_q, ready_d;
   logic              mem_en_q, mem_en_d;
   logic              burst_q, burst_d;
   logic [DATA_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] di_q, di_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              rv_q, rv_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [LEN_W-1:0]  beat_q, beat_d;
   logic [WAIT_W-1:0] wait_q, wait_d;

   logic              accept_c;
   logic              timeout_c;
   logic              last_beat_c;
   logic [LEN_W-1:0]  len_eff_c;

   assign accept_c    = (state == IDLE) && ready_q && bus.req_valid;
   assign timeout_c   = (wait_q == WAIT_LAST);
   assign last_beat_c = (beat_q == '0);
   assign len_eff_c   = (bus.req_len > LEN_MAX) ? LEN_MAX : bus.req_len;

   // state and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         ready_q  <= 1'b1;
         mem_en_q <= 1'b0;
         burst_q  <= 1'b0;
         addr_q   <= '0;
         di_q     <= '0;
         we_q     <= 1'b0;
         rdata_q  <= '0;
         rv_q     <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         beat_q   <= '0;
         wait_q   <= '0;
      end else begin
         state    <= state_d;
         ready_q  <= ready_d;
         mem_en_q <= mem_en_d;
         burst_q  <= burst_d;
         addr_q   <= addr_d;
         di_q     <= di_d;
         we_q     <= we_d;
         rdata_q  <= rdata_d;
         rv_q     <= rv_d;
         done_q   <= done_d;
         err_q    <= err_d;
         beat_q   <= beat_d;
         wait_q   <= wait_d;
      end
   end

   // next-state logic; an acknowledge always wins over a same-cycle timeout
   always_comb begin
      state_d = state;
      case (state)
         IDLE: begin
            if (accept_c) state_d = REQ;
         end
         REQ, BURST: begin
            if (bus.do_ack) state_d = last_beat_c ? DONE : BURST;
            else if (timeout_c) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // next values of the registered outputs and counters
   always_comb begin
      ready_d  = ready_q;
      mem_en_d = mem_en_q;
      burst_d  = burst_q;
      addr_d   = addr_q;
      di_d     = di_q;
      we_d     = we_q;
      rdata_d  = rdata_q;
      rv_d     = 1'b0;
      done_d   = 1'b0;
      err_d    = 1'b0;
      beat_d   = beat_q;
      wait_d   = wait_q;
      case (state)
         IDLE: begin
            ready_d = 1'b1;
            if (accept_c) begin
               ready_d  = 1'b0;
               mem_en_d = 1'b1;
               addr_d   = bus.req_addr;
               di_d     = bus.req_wdata;
               we_d     = bus.req_we;
               beat_d   = bus.req_we ? '0 : len_eff_c;
               burst_d  = !bus.req_we && (len_eff_c != '0);
               wait_d   = '0;
            end
         end
         REQ, BURST: begin
            if (bus.do_ack) begin
               wait_d = '0;
               if (!we_q) begin
                  rdata_d = bus.mem_do;
                  rv_d    = 1'b1;
               end
               if (last_beat_c) begin
                  mem_en_d = 1'b0;
                  burst_d  = 1'b0;
                  we_d     = 1'b0;
                  done_d   = 1'b1;
               end else begin
                  beat_d  = beat_q - LEN_W'(1);
                  addr_d  = addr_q + DATA_W'(1);
                  burst_d = (beat_q != LEN_W'(1));
               end
            end else if (timeout_c) begin
               mem_en_d = 1'b0;
               burst_d  = 1'b0;
               we_d     = 1'b0;
               done_d   = 1'b1;
               err_d    = 1'b1;
               wait_d   = '0;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         DONE:    ready_d = 1'b1;
         default: ready_d = 1'b1;
      endcase
   end

   assign bus.req_ready    = ready_q;
   assign bus.mem_en       = mem_en_q;
   assign bus.mem_burst_en = burst_q;
   assign bus.mem_addr     = addr_q;
   assign bus.mem_di       = di_q;
   assign bus.mem_we       = we_q;
   assign bus.rdata        = rdata_q;
   assign bus.rdata_valid  = rv_q;
   assign bus.done         = done_q;
   assign bus.err          = err_q;
endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: the bench plays user and arbiter, and predicts each cycle from
// the command (address sequence, beat count, chosen ack latencies, dropped beat).
module tb_mem_bus_master;
   localparam int unsigned TB_TIMEOUT = 8;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   mem_bus_master_if bus ();

   mem_bus_master #(.TIMEOUT(TB_TIMEOUT), .MAX_LEN(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: observed no end of run, expected finish before 2ms");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk1({tag, "_ready"}, bus.req_ready, 1'b1);
      chk1({tag, "_mem_en"}, bus.mem_en, 1'b0);
      chk1({tag, "_rvalid"}, bus.rdata_valid, 1'b0);
      chk1({tag, "_done"}, bus.done, 1'b0);
      chk1({tag, "_err"}, bus.err, 1'b0);
   endtask

   // One complete command; called at a negedge with the block idle, returns at the
   // negedge of the first idle cycle after the done pulse.
   task automatic run_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] len, input int drop_beat, input int lat_fix,
                          input logic [31:0] data_fix, input bit hold, input bit stray);
      int          beats;
      int          lat;
      bit          timed_out;
      bit          exp_rv;
      logic [31:0] exp_rdata;
      logic [31:0] ea;
      logic [31:0] d;
      beats     = we ? 1 : int'(len) + 1;
      timed_out = 1'b0;
      exp_rv    = 1'b0;
      exp_rdata = '0;
      chk1("accept_ready", bus.req_ready, 1'b1);
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      bus.req_len   = len;
      @(negedge clk);
      if (!hold) begin
         bus.req_valid = 1'b0;
         bus.req_we    = ~we;
         bus.req_addr  = $urandom;
         bus.req_wdata = $urandom;
         bus.req_len   = 4'($urandom);
      end
      for (int i = 0; i < beats && !timed_out; i++) begin
         ea  = addr + 32'(i);
         lat = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, TB_TIMEOUT - 1));
         for (int c = 0; c <= int'(TB_TIMEOUT); c++) begin
            chk1("mem_en", bus.mem_en, 1'b1);
            chk("mem_addr", bus.mem_addr, ea);
            chk1("mem_we", bus.mem_we, we);
            if (we) chk("mem_di", bus.mem_di, wdata);
            chk1("burst_en", bus.mem_burst_en, !we && (i < beats - 1));
            chk1("busy_ready", bus.req_ready, 1'b0);
            chk1("busy_done", bus.done, 1'b0);
            chk1("rdata_valid", bus.rdata_valid, exp_rv);
            if (exp_rv) chk("rdata", bus.rdata, exp_rdata);
            exp_rv = 1'b0;
            if (i == drop_beat) begin
               @(negedge clk);
               if (c == int'(TB_TIMEOUT) - 1) begin
                  timed_out = 1'b1;
                  break;
               end
            end else if (c == lat) begin
               d = (lat_fix >= 0) ? data_fix + 32'(i) : $urandom;
               bus.do_ack = 1'b1;
               bus.mem_do = d;
               @(negedge clk);
               bus.do_ack = 1'b0;
               bus.mem_do = $urandom;
               exp_rv     = !we;
               exp_rdata  = d;
               break;
            end else begin
               @(negedge clk);
            end
         end
      end
      chk1("done", bus.done, 1'b1);
      chk1("err", bus.err, timed_out);
      chk1("end_mem_en", bus.mem_en, 1'b0);
      chk1("end_burst_en", bus.mem_burst_en, 1'b0);
      chk1("end_mem_we", bus.mem_we, 1'b0);
      chk1("end_ready", bus.req_ready, 1'b0);
      chk1("end_rvalid", bus.rdata_valid, exp_rv);
      if (exp_rv) chk("end_rdata", bus.rdata, exp_rdata);
      bus.req_valid = 1'b0;
      bus.do_ack    = stray;
      bus.mem_do    = $urandom;
      @(negedge clk);
      bus.do_ack = 1'b0;
      chk_idle("post_done");
   endtask

   initial begin
      reset         = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.req_len   = '0;
      bus.do_ack    = 1'b0;
      bus.mem_do    = '0;
      repeat (2) @(negedge clk);
      chk_idle("reset");
      chk("reset_addr", bus.mem_addr, 32'h0);
      chk("reset_rdata", bus.rdata, 32'h0);
      reset = 1'b0;

      // single read right after reset release, three idle cycles before the ack
      run_txn(1'b0, 32'h0000_0010, 32'h0, 4'd0, -1, 3, 32'hDEAD_BEEF, 1'b0, 1'b0);
      // single write, data held until ack
      run_txn(1'b1, 32'h0000_0020, 32'hA5A5_A5A5, 4'd5, -1, 2, 32'h0, 1'b0, 1'b0);
      // burst across the 32-bit address wrap with back-to-back acks
      run_txn(1'b0, 32'hFFFF_FFFE, 32'h0, 4'd3, -1, 0, 32'h1000_0000, 1'b0, 1'b0);
      // never acknowledged single read, then a burst dropping its third beat
      run_txn(1'b0, 32'h0000_0100, 32'h0, 4'd0, 0, 1, 32'h0, 1'b0, 1'b0);
      run_txn(1'b0, 32'h0000_0200, 32'h0, 4'd4, 2, 1, 32'h2000_0000, 1'b0, 1'b0);
      // ack on the last cycle before the timeout would fire
      run_txn(1'b0, 32'h0000_0300, 32'h0, 4'd1, -1, int'(TB_TIMEOUT) - 1, 32'h3000_0000, 1'b0, 1'b0);
      // request held valid through the transfer, stray ack during done
      run_txn(1'b0, 32'h0000_0400, 32'h0, 4'd2, -1, 1, 32'h4000_0000, 1'b1, 1'b1);
      run_txn(1'b1, 32'h0000_0500, 32'h1234_5678, 4'd0, -1, 0, 32'h0, 1'b1, 1'b1);

      // stray ack while idle
      bus.do_ack = 1'b1;
      bus.mem_do = 32'hCAFE_F00D;
      @(negedge clk);
      bus.do_ack = 1'b0;
      chk_idle("stray_idle");
      @(negedge clk);
      chk_idle("stray_idle2");

      // reset during beat 2 of a len-7 burst
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b0;
      bus.req_addr  = 32'h0000_0800;
      bus.req_len   = 4'd7;
      @(negedge clk);
      bus.req_valid = 1'b0;
      for (int b = 0; b < 2; b++) begin
         chk("rst_burst_addr", bus.mem_addr, 32'h0000_0800 + 32'(b));
         bus.do_ack = 1'b1;
         bus.mem_do = $urandom;
         @(negedge clk);
         bus.do_ack = 1'b0;
      end
      chk("rst_beat2_addr", bus.mem_addr, 32'h0000_0802);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk_idle("mid_reset");
      chk1("mid_reset_burst", bus.mem_burst_en, 1'b0);
      chk1("mid_reset_we", bus.mem_we, 1'b0);
      chk("mid_reset_addr", bus.mem_addr, 32'h0);
      chk("mid_reset_rdata", bus.rdata, 32'h0);
      @(negedge clk);
      chk_idle("after_reset");

      // randomized commands
      for (int n = 0; n < 40; n++) begin
         bit          we;
         logic [31:0] addr;
         logic [3:0]  len;
         int          drop;
         we   = ($urandom_range(0, 3) == 0);
         addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
         len  = 4'($urandom);
         drop = -1;
         if ($urandom_range(0, 7) == 0) drop = int'($urandom_range(0, we ? 0 : int'(len)));
         run_txn(we, addr, $urandom, len, drop, -1, 32'h0, 1'($urandom), 1'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
